// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension unit: extension mode encodings
// and the width of the mode field.
package imm_ext_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] ext_mode_t;

  localparam ext_mode_t EXT_SEXT = 2'b00;
  localparam ext_mode_t EXT_ZEXT = 2'b01;
  localparam ext_mode_t EXT_LUI  = 2'b10;
  localparam ext_mode_t EXT_BR   = 2'b11;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-side and ALU-side valid/ready bundle of the immediate-extension FIFO.
// The slave modport is the extension unit, the master modport its environment.
interface imm_extend_pipe_if
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic              in_valid;
  logic              in_ready;
  ext_mode_t         in_mode;
  logic [IN_W-1:0]   in_imm;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_neg;

  modport slave (
    input  in_valid, in_mode, in_imm, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_neg
  );

  modport master (
    output in_valid, in_mode, in_imm, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_neg
  );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational extension of a raw immediate into an operand-width word
// according to the selected mode.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  ext_mode_t        mode_i,
  input  logic [IN_W-1:0]  imm_i,
  output logic [OUT_W-1:0] ext_o
);

  logic [OUT_W-1:0] sext_w;

  assign sext_w = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

  always_comb begin
    ext_o = '0;
    case (mode_i)
      EXT_SEXT: ext_o = sext_w;
      EXT_ZEXT: ext_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
      EXT_LUI:  ext_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
      // The top two sign copies fall off; OUT_W >= IN_W+2 keeps them redundant.
      EXT_BR:   ext_o = {sext_w[OUT_W-3:0], 2'b00};
      default:  ext_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Buffered immediate-extension stage: extends on entry, then queues the
// result with its tag in a small register FIFO ahead of the ALU operand mux.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  imm_extend_pipe_if.slave       bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
  end
  if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("imm_extend_pipe: DEPTH must be a power of 2");
  end

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             neg;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           wr_entry;
  logic [OUT_W-1:0] ext_w;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .mode_i (bus.in_mode),
    .imm_i  (bus.in_imm),
    .ext_o  (ext_w)
  );

  // in_ready depends only on registered occupancy and flush, never on out_ready.
  assign bus.in_ready  = (count_q < DEPTH_C) & ~flush;
  assign bus.out_valid = (count_q != '0);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready & ~flush;

  assign wr_entry = '{data: ext_w, tag: bus.in_tag, neg: bus.in_imm[IN_W-1]};

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PTR_ONE;
      if (pop)  rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wr_entry;
  end

  assign bus.out_data = bus.out_valid ? mem_q[rd_q].data : '0;
  assign bus.out_tag  = bus.out_valid ? mem_q[rd_q].tag  : '0;
  assign bus.out_neg  = bus.out_valid ? mem_q[rd_q].neg  : 1'b0;
  assign count        = count_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomised self-checking bench for imm_extend_pipe against a queue-based
// reference model with arithmetic extension rules.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int DEPTH = 2;
  localparam int TAG_W = 5;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] count;

  imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        neg;
  } ent_t;

  ent_t model_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Extension rules as plain integer arithmetic on the immediate's value.
  function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] imm);
    longint uval, sval, r;
    uval = longint'(imm);
    sval = imm[15] ? uval - 65536 : uval;
    case (m)
      2'd0:    r = sval;
      2'd1:    r = uval;
      2'd2:    r = uval * 65536;
      default: r = sval * 4;
    endcase
    return r[31:0];
  endfunction

  // Advance one clock edge and apply the same transfer to the model.
  task automatic step();
    bit   do_push, do_pop, do_flush;
    ent_t e;
    do_flush = flush;
    do_push  = bus.in_valid && (model_q.size() < DEPTH) && !flush;
    do_pop   = bus.out_ready && (model_q.size() > 0);
    e.data   = ref_ext(bus.in_mode, bus.in_imm);
    e.tag    = bus.in_tag;
    e.neg    = bus.in_imm[15];
    @(posedge clk);
    #1;
    if (do_flush) model_q.delete();
    else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
  endtask

  task automatic drive_word(input logic [1:0] m, input logic [15:0] imm, input logic [4:0] tag);
    bus.in_mode = m;
    bus.in_imm  = imm;
    bus.in_tag  = tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive_word(2'd0, 16'h0, 5'd0);
    #2;
    n_checks++;
    if (count !== 2'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d out_valid=%b, required 0/0", count, bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== 32'h0 || bus.out_tag !== 5'd0 || bus.out_neg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h tag=%0d neg=%b, required 0", bus.out_data, bus.out_tag, bus.out_neg);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_modes();
    logic [1:0]  m_t[6]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [15:0] imm_t[6] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h0004, 16'h7FFF};
    logic [31:0] exp_t[6] = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC, 32'h00000010, 32'h00007FFF};
    for (int i = 0; i < 36; i++) begin
      logic [1:0]  m;
      logic [15:0] imm;
      logic [31:0] exp_d;
      if (i < 6) begin
        m = m_t[i]; imm = imm_t[i]; exp_d = exp_t[i];
      end else begin
        m = 2'($urandom_range(0, 3)); imm = 16'($urandom); exp_d = ref_ext(m, imm);
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      drive_word(m, imm, 5'(i));
      step();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_tag !== 5'(i) || bus.out_neg !== imm[15]) begin
        n_fail++;
        $display("FAIL mode_%0d imm=%h: valid=%b data=%h tag=%0d neg=%b, required 1/%h/%0d/%b",
                 m, imm, bus.out_valid, bus.out_data, bus.out_tag, bus.out_neg, exp_d, 5'(i), imm[15]);
      end
      bus.out_ready = 1'b1;
      step();
      n_checks++;
      if (count !== 2'd0 || bus.out_data !== 32'h0) begin
        n_fail++;
        $display("FAIL mode_pop: count=%0d data=%h, required 0/0", count, bus.out_data);
      end
    end
    bus.out_ready = 1'b0;
    $display("test_modes done");
  endtask

  task automatic test_backpressure();
    int got[$];
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int t = 1; t <= 2; t++) begin
      drive_word(2'($urandom_range(0, 3)), 16'($urandom), 5'(t));
      step();
    end
    n_checks++;
    if (count !== 2'd2 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: count=%0d in_ready=%b, required 2/0", count, bus.in_ready);
    end
    drive_word(2'($urandom_range(0, 3)), 16'($urandom), 5'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (count !== 2'd2 || bus.out_tag !== 5'd1) begin
        n_fail++;
        $display("FAIL bp_hold: count=%0d head_tag=%0d, required 2/1", count, bus.out_tag);
      end
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12 && got.size() < 3; k++) begin
      bit acc;
      acc = bus.in_valid && (model_q.size() < DEPTH);
      if (bus.out_valid) begin
        got.push_back(int'(bus.out_tag));
        n_checks++;
        if (model_q.size() == 0 || bus.out_data !== model_q[0].data) begin
          n_fail++;
          $display("FAIL bp_data: got %h, required head of model", bus.out_data);
        end
      end
      step();
      if (acc) bus.in_valid = 1'b0;
    end
    n_checks++;
    if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 3) begin
      n_fail++;
      $display("FAIL bp_order: got %p, required '{1,2,3}", got);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    $display("test_backpressure done");
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_word(2'($urandom_range(0, 3)), 16'($urandom), 5'(i + 4));
      step();
      n_checks++;
      if (count !== 2'd1 || bus.in_ready !== 1'b1 || bus.out_tag !== 5'(i + 4) ||
          model_q.size() != 1 || bus.out_data !== model_q[0].data) begin
        n_fail++;
        $display("FAIL stream_%0d: count=%0d tag=%0d data=%h, required 1/%0d/model head",
                 i, count, bus.out_tag, bus.out_data, 5'(i + 4));
      end
    end
    bus.in_valid = 1'b0;
    step();
    n_checks++;
    if (count !== 2'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: count=%0d valid=%b, required 0/0", count, bus.out_valid);
    end
    bus.out_ready = 1'b0;
    $display("test_streaming done");
  endtask

  task automatic test_full_pop();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int t = 0; t < 2; t++) begin
      drive_word(2'($urandom_range(0, 3)), 16'($urandom), 5'(10 + t));
      step();
    end
    drive_word(2'd1, 16'h00AA, 5'd12);
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_same: in_ready=%b, required 0", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || count !== 2'd1 || bus.out_tag !== 5'd11) begin
      n_fail++;
      $display("FAIL full_pop_next: in_ready=%b count=%0d tag=%0d, required 1/1/11", bus.in_ready, count, bus.out_tag);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4 && model_q.size() > 0; k++) step();
    bus.out_ready = 1'b0;
    $display("test_full_pop done");
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int t = 0; t < 2; t++) begin
      drive_word(2'($urandom_range(0, 3)), 16'($urandom), 5'(20 + t));
      step();
    end
    drive_word(2'd0, 16'h1111, 5'd9);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (count !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_clear: count=%0d valid=%b data=%h, required 0/0/0", count, bus.out_valid, bus.out_data);
    end
    step();
    n_checks++;
    if (count !== 2'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_dropped: count=%0d valid=%b, required 0/0", count, bus.out_valid);
    end
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_word(2'd1, 16'hBEEF, 5'd17);
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (count !== 2'd1 || bus.out_data !== 32'h0000BEEF) begin
      n_fail++;
      $display("FAIL areset_pre: count=%0d data=%h, required 1/0000beef", count, bus.out_data);
    end
    #3 rst_n = 1'b0;
    #1;
    model_q.delete();
    n_checks++;
    if (count !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL areset_now: count=%0d valid=%b data=%h, required 0/0/0", count, bus.out_valid, bus.out_data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    drive_word(2'd0, 16'h7FFF, 5'd7);
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00007FFF || bus.out_tag !== 5'd7) begin
      n_fail++;
      $display("FAIL areset_after: valid=%b data=%h tag=%0d, required 1/00007fff/7", bus.out_valid, bus.out_data, bus.out_tag);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bit exp_rdy;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 15) == 0);
      drive_word(2'($urandom_range(0, 3)), 16'($urandom), 5'($urandom));
      #1;
      exp_rdy = (model_q.size() < DEPTH) && !flush;
      n_checks++;
      if (bus.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_in_ready_%0d: got %b, required %b", i, bus.in_ready, exp_rdy);
      end
      step();
      n_checks++;
      if (model_q.size() == 0) begin
        if (count !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_tag !== 5'd0 || bus.out_neg !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_empty_%0d: count=%0d valid=%b data=%h tag=%0d neg=%b, required all 0",
                   i, count, bus.out_valid, bus.out_data, bus.out_tag, bus.out_neg);
        end
      end else if (count !== 2'(model_q.size()) || bus.out_valid !== 1'b1 || bus.out_data !== model_q[0].data ||
                   bus.out_tag !== model_q[0].tag || bus.out_neg !== model_q[0].neg) begin
        n_fail++;
        $display("FAIL rand_head_%0d: count=%0d data=%h tag=%0d neg=%b, required %0d/%h/%0d/%b",
                 i, count, bus.out_data, bus.out_tag, bus.out_neg,
                 model_q.size(), model_q[0].data, model_q[0].tag, model_q[0].neg);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_streaming();
    test_full_pop();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
